// File: rtl/cursor_ctrl_pkg.sv
// Shared types, constants and edge-step helpers for the checkers cursor controller.
// Build option CURSOR_WRAP_EN: cursor wraps modulo 8 at board edges instead of saturating.
package checkers_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NAV  = 2'd1,
      SEL  = 2'd2,
      REQ  = 2'd3
   } cur_state_t;

   typedef logic [5:0] sq_t;

   localparam int BOARD_N     = 8;
   localparam int SQ_SIZE_DEF = 14;

   function automatic logic [2:0] step_inc(input logic [2:0] v);
`ifdef CURSOR_WRAP_EN
      return v + 3'd1;
`else
      return (v == 3'(BOARD_N - 1)) ? v : v + 3'd1;
`endif
   endfunction

   function automatic logic [2:0] step_dec(input logic [2:0] v);
`ifdef CURSOR_WRAP_EN
      return v - 3'd1;
`else
      return (v == 3'd0) ? v : v - 3'd1;
`endif
   endfunction

   function automatic sq_t sq_pack(input logic [2:0] row, input logic [2:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/cursor_ctrl_if.sv
// Move-request handshake between the cursor controller (master) and game logic (slave).
interface cursor_move_if;
   import checkers_pkg::*;

   logic move_req;
   logic move_ack;
   logic move_nack;
   sq_t  src_sq;
   sq_t  dst_sq;

   modport master (output move_req, src_sq, dst_sq, input move_ack, move_nack);
   modport slave  (input move_req, src_sq, dst_sq, output move_ack, move_nack);

endinterface

// File: rtl/cursor_loc_map.sv
// Maps a board square (col,row) to the icon top-left in logic pixels, registered every cycle.
module cursor_loc_map
   import checkers_pkg::*;
#(
   parameter int BOARD_X0  = 72,
   parameter int BOARD_Y0  = 40,
   parameter int SQ_SIZE   = SQ_SIZE_DEF,
   parameter int START_COL = 0,
   parameter int START_ROW = 7
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] col_i,
   input  logic [2:0] row_i,
   output logic [7:0] pend_x_o,
   output logic [7:0] pend_y_o
);

   localparam logic [7:0] RST_X = 8'(BOARD_X0 + SQ_SIZE * START_COL);
   localparam logic [7:0] RST_Y = 8'(BOARD_Y0 + SQ_SIZE * START_ROW);

   logic [7:0] x_d, y_d, x_q, y_q;

   always_comb begin
      x_d = 8'(BOARD_X0 + SQ_SIZE * int'(col_i));
      y_d = 8'(BOARD_Y0 + SQ_SIZE * int'(row_i));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q <= RST_X;
         y_q <= RST_Y;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign pend_x_o = x_q;
   assign pend_y_o = y_q;

endmodule

// File: rtl/cursor_ctrl.sv
// Checkers cursor controller: navigation FSM, source/destination pick, move handshake,
// and frame-synchronised icon position. Edge behaviour selected by CURSOR_WRAP_EN.
module cursor_ctrl
   import checkers_pkg::*;
#(
   parameter int BOARD_X0  = 72,
   parameter int BOARD_Y0  = 40,
   parameter int SQ_SIZE   = SQ_SIZE_DEF,
   parameter int START_COL = 0,
   parameter int START_ROW = 7
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          btn_up,
   input  logic          btn_dn,
   input  logic          btn_lt,
   input  logic          btn_rt,
   input  logic          btn_sel,
   input  logic          my_turn,
   input  logic          frame_start,
   cursor_move_if.master mv,
   output logic [7:0]    locX,
   output logic [7:0]    locY,
   output logic          cursor_en,
   output logic          sel_active
);

   localparam logic [2:0] START_C = 3'(START_COL);
   localparam logic [2:0] START_R = 3'(START_ROW);
   localparam logic [7:0] RST_X   = 8'(BOARD_X0 + SQ_SIZE * START_COL);
   localparam logic [7:0] RST_Y   = 8'(BOARD_Y0 + SQ_SIZE * START_ROW);

   cur_state_t state_q, state_d;
   logic [2:0] col_q, col_d, row_q, row_d;
   logic [2:0] step_col_s, step_row_s;
   sq_t        src_q, src_d, dst_q, dst_d, cur_s;
   logic       sel_q, sel_d, req_q, req_d;
   logic [7:0] pend_x_s, pend_y_s, locx_q, locy_q;
   logic       pend_en_q, en_q;

   cursor_loc_map #(
      .BOARD_X0 (BOARD_X0),
      .BOARD_Y0 (BOARD_Y0),
      .SQ_SIZE  (SQ_SIZE),
      .START_COL(START_COL),
      .START_ROW(START_ROW)
   ) u_map (
      .clk     (clk),
      .reset_n (reset_n),
      .col_i   (col_q),
      .row_i   (row_q),
      .pend_x_o(pend_x_s),
      .pend_y_o(pend_y_s)
   );

   assign cur_s = sq_pack(row_q, col_q);

   // One direction step per cycle, priority up > dn > lt > rt.
   always_comb begin
      step_col_s = col_q;
      step_row_s = row_q;
      if (btn_up) begin
         step_row_s = step_dec(row_q);
      end else if (btn_dn) begin
         step_row_s = step_inc(row_q);
      end else if (btn_lt) begin
         step_col_s = step_dec(col_q);
      end else if (btn_rt) begin
         step_col_s = step_inc(col_q);
      end else begin
         step_col_s = col_q;
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      src_d   = src_q;
      dst_d   = dst_q;
      sel_d   = sel_q;
      req_d   = req_q;
      case (state_q)
         IDLE: begin
            if (my_turn) begin
               state_d = NAV;
               col_d   = START_C;
               row_d   = START_R;
            end else begin
               state_d = IDLE;
            end
         end
         NAV: begin
            if (!my_turn) begin
               state_d = IDLE;
               sel_d   = 1'b0;
            end else if (btn_sel) begin
               state_d = SEL;
               src_d   = cur_s;
               sel_d   = 1'b1;
            end else begin
               col_d = step_col_s;
               row_d = step_row_s;
            end
         end
         SEL: begin
            if (!my_turn) begin
               state_d = IDLE;
               sel_d   = 1'b0;
            end else if (btn_sel) begin
               // Selecting the source square again cancels the pick.
               if (cur_s == src_q) begin
                  state_d = NAV;
                  sel_d   = 1'b0;
               end else begin
                  state_d = REQ;
                  dst_d   = cur_s;
                  req_d   = 1'b1;
               end
            end else begin
               col_d = step_col_s;
               row_d = step_row_s;
            end
         end
         REQ: begin
            if (mv.move_ack) begin
               state_d = IDLE;
               sel_d   = 1'b0;
               req_d   = 1'b0;
            end else if (mv.move_nack) begin
               state_d = NAV;
               sel_d   = 1'b0;
               req_d   = 1'b0;
            end else begin
               state_d = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         col_q   <= START_C;
         row_q   <= START_R;
         src_q   <= 6'd0;
         dst_q   <= 6'd0;
         sel_q   <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         sel_q   <= sel_d;
         req_q   <= req_d;
      end
   end

   // Icon outputs only move at frame start so the sprite never tears mid-frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_en_q <= 1'b0;
         locx_q    <= RST_X;
         locy_q    <= RST_Y;
         en_q      <= 1'b0;
      end else begin
         pend_en_q <= (state_q != IDLE);
         if (frame_start) begin
            locx_q <= pend_x_s;
            locy_q <= pend_y_s;
            en_q   <= pend_en_q;
         end
      end
   end

   assign locX        = locx_q;
   assign locY        = locy_q;
   assign cursor_en   = en_q;
   assign sel_active  = sel_q;
   assign mv.move_req = req_q;
   assign mv.src_sq   = src_q;
   assign mv.dst_sq   = dst_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Bench for cursor_ctrl: directed scenarios plus randomized traffic against a square-level model.
module tb_cursor_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n, btn_up, btn_dn, btn_lt, btn_rt, btn_sel, my_turn, frame_start;
   logic [7:0] locX, locY;
   logic       cursor_en, sel_active;

   cursor_move_if mv ();

   cursor_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn_up     (btn_up),
      .btn_dn     (btn_dn),
      .btn_lt     (btn_lt),
      .btn_rt     (btn_rt),
      .btn_sel    (btn_sel),
      .my_turn    (my_turn),
      .frame_start(frame_start),
      .mv         (mv),
      .locX       (locX),
      .locY       (locY),
      .cursor_en  (cursor_en),
      .sel_active (sel_active)
   );

   int checks = 0;
   int errors = 0;

   // Model: mode 0 idle, 1 navigating, 2 source picked, 3 waiting for game logic.
   int   m_mode, m_col, m_row, m_src, m_dst, m_px, m_py, m_ox, m_oy;
   logic m_sel, m_req, m_pen, m_oen;

   function automatic int axis(int v, int d);
      int n;
      n = v + d;
`ifdef CURSOR_WRAP_EN
      return (n + 8) % 8;
`else
      if (n < 0) return 0;
      if (n > 7) return 7;
      return n;
`endif
   endfunction

   task automatic model_reset();
      m_mode = 0; m_col = 0; m_row = 7; m_src = 0; m_dst = 0;
      m_sel = 1'b0; m_req = 1'b0; m_pen = 1'b0; m_oen = 1'b0;
      m_px = 72; m_py = 138; m_ox = 72; m_oy = 138;
   endtask

   task automatic model_edge();
      int dr, dc, sq;
      dr = 0; dc = 0;
      sq = m_row * 8 + m_col;
      if (frame_start) begin
         m_ox = m_px; m_oy = m_py; m_oen = m_pen;
      end
      m_px  = 72 + 14 * m_col;
      m_py  = 40 + 14 * m_row;
      m_pen = (m_mode != 0);
      if (btn_up) dr = -1;
      else if (btn_dn) dr = 1;
      else if (btn_lt) dc = -1;
      else if (btn_rt) dc = 1;
      case (m_mode)
         0: if (my_turn) begin m_mode = 1; m_col = 0; m_row = 7; end
         1, 2: begin
            if (!my_turn) begin
               m_mode = 0; m_sel = 1'b0;
            end else if (btn_sel) begin
               if (m_mode == 1) begin m_src = sq; m_sel = 1'b1; m_mode = 2; end
               else if (sq == m_src) begin m_mode = 1; m_sel = 1'b0; end
               else begin m_dst = sq; m_req = 1'b1; m_mode = 3; end
            end else begin
               m_col = axis(m_col, dc);
               m_row = axis(m_row, dr);
            end
         end
         3: begin
            if (mv.move_ack) begin m_mode = 0; m_sel = 1'b0; m_req = 1'b0; end
            else if (mv.move_nack) begin m_mode = 1; m_sel = 1'b0; m_req = 1'b0; end
         end
         default: ;
      endcase
   endtask

   task automatic cyc(input logic u, d, l, r, s, fs, ak, nk);
      btn_up = u; btn_dn = d; btn_lt = l; btn_rt = r; btn_sel = s;
      frame_start = fs; mv.move_ack = ak; mv.move_nack = nk;
      @(posedge clk);
      model_edge();
      #1;
      btn_up = 1'b0; btn_dn = 1'b0; btn_lt = 1'b0; btn_rt = 1'b0; btn_sel = 1'b0;
      frame_start = 1'b0; mv.move_ack = 1'b0; mv.move_nack = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; my_turn = 1'b0;
      btn_up = 1'b0; btn_dn = 1'b0; btn_lt = 1'b0; btn_rt = 1'b0; btn_sel = 1'b0;
      frame_start = 1'b0; mv.move_ack = 1'b0; mv.move_nack = 1'b0;
      model_reset();
      #23;
      @(negedge clk);
      reset_n = 1'b1;
      checks++; if (locX !== 8'd72 || locY !== 8'd138) begin errors++;
         $display("FAIL reset_loc: got %0d,%0d expected 72,138", locX, locY); end
      checks++; if ({cursor_en, sel_active, mv.move_req} !== 3'b000) begin errors++;
         $display("FAIL reset_flags: got %b expected 000", {cursor_en, sel_active, mv.move_req}); end
      checks++; if (mv.src_sq !== 6'd0 || mv.dst_sq !== 6'd0) begin errors++;
         $display("FAIL reset_sq: got %o,%o expected 0,0", mv.src_sq, mv.dst_sq); end
   endtask

   task automatic test_first_frame();
      my_turn = 1'b1;
      idle(3);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      checks++; if (locX !== 8'd72 || locY !== 8'd138 || cursor_en !== 1'b1) begin errors++;
         $display("FAIL first_frame: got %0d,%0d,%b expected 72,138,1", locX, locY, cursor_en); end
   endtask

   task automatic test_move();
      repeat (4) cyc(0, 0, 0, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      checks++; if (locX !== 8'd72 || locY !== 8'd138) begin errors++;
         $display("FAIL move_before_frame: got %0d,%0d expected 72,138", locX, locY); end
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      checks++; if (locX !== 8'd128 || locY !== 8'd124) begin errors++;
         $display("FAIL move_after_frame: got %0d,%0d expected 128,124", locX, locY); end
   endtask

   task automatic test_edge();
      logic [7:0] exp_x;
`ifdef CURSOR_WRAP_EN
      exp_x = 8'd72;
`else
      exp_x = 8'd170;
`endif
      repeat (4) cyc(0, 0, 0, 1, 0, 0, 0, 0);
      idle(2);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      checks++; if (locX !== exp_x || locY !== 8'd124) begin errors++;
         $display("FAIL edge_col: got %0d,%0d expected %0d,124", locX, locY, exp_x); end
   endtask

   task automatic test_pick_nack();
      my_turn = 1'b0; idle(1);
      my_turn = 1'b1; idle(1);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      checks++; if (sel_active !== 1'b1 || mv.move_req !== 1'b0) begin errors++;
         $display("FAIL pick_src: got sel=%b req=%b expected 1,0", sel_active, mv.move_req); end
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      checks++; if (mv.move_req !== 1'b1 || mv.src_sq !== 6'o70 || mv.dst_sq !== 6'o61) begin errors++;
         $display("FAIL pick_req: got req=%b src=%o dst=%o expected 1,70,61", mv.move_req, mv.src_sq, mv.dst_sq); end
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (mv.move_req !== 1'b0 || sel_active !== 1'b0) begin errors++;
         $display("FAIL nack_clear: got req=%b sel=%b expected 0,0", mv.move_req, sel_active); end
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      checks++; if (locX !== 8'd86 || locY !== 8'd110) begin errors++;
         $display("FAIL nack_nav: got %0d,%0d expected 86,110", locX, locY); end
   endtask

   task automatic test_sel_priority();
      cyc(1, 0, 0, 0, 1, 0, 0, 0);
      idle(2);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      checks++; if (sel_active !== 1'b1 || locY !== 8'd110 || locX !== 8'd86) begin errors++;
         $display("FAIL sel_beats_dir: got sel=%b loc=%0d,%0d expected 1,86,110", sel_active, locX, locY); end
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      checks++; if (sel_active !== 1'b0 || mv.move_req !== 1'b0) begin errors++;
         $display("FAIL sel_cancel: got sel=%b req=%b expected 0,0", sel_active, mv.move_req); end
   endtask

   task automatic test_ack_wins();
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      my_turn = 1'b0;
      idle(3);
      checks++; if (mv.move_req !== 1'b1 || sel_active !== 1'b1 || mv.dst_sq !== 6'o52) begin errors++;
         $display("FAIL req_hold: got req=%b sel=%b dst=%o expected 1,1,52", mv.move_req, sel_active, mv.dst_sq); end
      cyc(0, 0, 0, 0, 0, 0, 1, 1);
      checks++; if (mv.move_req !== 1'b0 || sel_active !== 1'b0) begin errors++;
         $display("FAIL ack_clear: got req=%b sel=%b expected 0,0", mv.move_req, sel_active); end
      idle(3);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      checks++; if (cursor_en !== 1'b0) begin errors++;
         $display("FAIL ack_wins_idle: got en=%b expected 0", cursor_en); end
   endtask

   task automatic test_reset_mid_req();
      my_turn = 1'b1;
      idle(4);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      my_turn = 1'b0;
      idle(2);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      checks++; if (mv.move_req !== 1'b1 || cursor_en !== 1'b1 || locX !== 8'd86) begin errors++;
         $display("FAIL pre_reset: got req=%b en=%b x=%0d expected 1,1,86", mv.move_req, cursor_en, locX); end
      reset_n = 1'b0;
      #1;
      model_reset();
      checks++; if (mv.move_req !== 1'b0 || cursor_en !== 1'b0 || sel_active !== 1'b0) begin errors++;
         $display("FAIL async_reset_flags: got req=%b en=%b sel=%b expected 0,0,0", mv.move_req, cursor_en, sel_active); end
      checks++; if (locX !== 8'd72 || locY !== 8'd138) begin errors++;
         $display("FAIL async_reset_loc: got %0d,%0d expected 72,138", locX, locY); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_random();
      logic u, d, l, r, s, fs, ak, nk;
      my_turn = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 59) == 0) my_turn = ~my_turn;
         u  = ($urandom_range(0, 6) == 0);
         d  = ($urandom_range(0, 6) == 0);
         l  = ($urandom_range(0, 6) == 0);
         r  = ($urandom_range(0, 6) == 0);
         s  = ($urandom_range(0, 7) == 0);
         fs = ($urandom_range(0, 5) == 0);
         ak = ($urandom_range(0, 7) == 0);
         nk = ($urandom_range(0, 5) == 0);
         cyc(u, d, l, r, s, fs, ak, nk);
         checks++;
         if (locX !== 8'(m_ox) || locY !== 8'(m_oy) || cursor_en !== m_oen) begin errors++;
            $display("FAIL rand_icon @%0d: got %0d,%0d,%b expected %0d,%0d,%b",
                     i, locX, locY, cursor_en, m_ox, m_oy, m_oen); end
         checks++;
         if (sel_active !== m_sel || mv.move_req !== m_req ||
             mv.src_sq !== 6'(m_src) || mv.dst_sq !== 6'(m_dst)) begin errors++;
            $display("FAIL rand_pick @%0d: got sel=%b req=%b src=%o dst=%o expected %b,%b,%o,%o",
                     i, sel_active, mv.move_req, mv.src_sq, mv.dst_sq, m_sel, m_req, m_src, m_dst); end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_move();
      test_edge();
      test_pick_nack();
      test_sel_priority();
      test_ack_wins();
      test_reset_mid_req();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
